// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: EX-stage sequencer for the iterative DIV/DIVU unit.
// Ports: clk/resetn; req_* in, req_ready out; cancel; div_* to/from the
// divider; mthi_we/mtlo_we/mt_data; hi/lo; busy, done, timeout_err.
module div_seq_ctrl #(
  parameter int TIMEOUT   = 40,
  parameter int DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_unsigned,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic        req_ready,
  input  logic        cancel,
  output logic        div_begin,
  output logic        div_unsigned,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [63:0] div_product,
  input  logic        div_end,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int RW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYC + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB,
    DRAIN
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] run_cnt, run_cnt_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic          begin_n, uns_n;
  logic [31:0]   op1_n, op2_n;
  logic [31:0]   hi_n, lo_n;
  logic          done_n, tmo_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= DRAIN;
      run_cnt      <= '0;
      drain_cnt    <= DW'(DRAIN_CYC);
      div_begin    <= 1'b0;
      div_unsigned <= 1'b0;
      div_op1      <= '0;
      div_op2      <= '0;
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      req_ready    <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_n;
      run_cnt      <= run_cnt_n;
      drain_cnt    <= drain_n;
      div_begin    <= begin_n;
      div_unsigned <= uns_n;
      div_op1      <= op1_n;
      div_op2      <= op2_n;
      hi           <= hi_n;
      lo           <= lo_n;
      done         <= done_n;
      timeout_err  <= tmo_n;
      req_ready    <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    run_cnt_n = run_cnt;
    drain_n   = drain_cnt;
    begin_n   = div_begin;
    uns_n     = div_unsigned;
    op1_n     = div_op1;
    op2_n     = div_op2;
    hi_n      = hi;
    lo_n      = lo;
    done_n    = 1'b0;
    tmo_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (mthi_we) hi_n = mt_data;
        if (mtlo_we) lo_n = mt_data;
        if (req_valid && !cancel) begin
          op1_n     = req_op1;
          op2_n     = req_op2;
          uns_n     = req_unsigned;
          begin_n   = 1'b1;
          run_cnt_n = '0;
          state_n   = RUN;
        end
      end
      RUN: begin
        run_cnt_n = run_cnt + RW'(1);
        // cancel beats a coincident div_end: the instruction is flushed
        if (cancel) begin
          begin_n = 1'b0;
          drain_n = DW'(DRAIN_CYC);
          state_n = DRAIN;
        end else if (div_end) begin
          begin_n = 1'b0;
          hi_n    = div_product[63:32];
          lo_n    = div_product[31:0];
          done_n  = 1'b1;
          state_n = WB;
        end else if (run_cnt == RW'(TIMEOUT - 1)) begin
          begin_n = 1'b0;
          tmo_n   = 1'b1;
          drain_n = DW'(DRAIN_CYC);
          state_n = DRAIN;
        end
      end
      WB: begin
        drain_n = DW'(DRAIN_CYC);
        state_n = DRAIN;
      end
      DRAIN: begin
        // divider has no reset; keep begin low long enough to clear it
        drain_n = drain_cnt - DW'(1);
        if (drain_cnt <= DW'(1)) begin
          drain_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = DRAIN;
    endcase
  end

endmodule
